// File: rtl/priority_pkg.sv
// Shared definitions for the priority encoder/decoder pair: FSM state
// encoding and the reversed code-to-bit mapping (code c -> bit N-1-c).
package priority_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Returns a one-hot word with bit n-1-c set, or zero for c >= n.
    function automatic logic [15:0] code_to_bit(
        input int unsigned c,
        input int unsigned n
    );
        if (c < n)
            return 16'(1) << (n - 1 - c);
        return 16'd0;
    endfunction

endpackage

// File: rtl/priority_decoder_if.sv
// Code handshake bundle between a code producer (master) and the decoder
// (slave). Ports: code_valid, code (master->slave); code_ready (slave->master).
interface priority_decoder_if #(
    parameter int CODE_WIDTH = 2
);
    logic                  code_valid;
    logic                  code_ready;
    logic [CODE_WIDTH-1:0] code;

    modport master (
        output code_valid,
        output code,
        input  code_ready
    );

    modport slave (
        input  code_valid,
        input  code,
        output code_ready
    );
endinterface

// File: rtl/priority_decoder_cnt.sv
// Loadable down-counter shared by the HOLD and GAP phases.
// Ports: clk, rst_n, load, load_val, dec, zero (count == 0).
module priority_decoder_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    assign zero = (cnt == '0);

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/priority_decoder.sv
// Expands accepted index codes into a one-hot strobe held HOLD_CYCLES then
// zeroed GAP_CYCLES; code c drives bit INPUTS-1-c, codes >= INPUTS pulse err.
// Ports: clk, rst_n, bus (code_valid/code/code_ready), onehot, busy, err,
// acc, acc_clr. Optional accumulator: PRIORITY_DECODER_ACC_EN.
module priority_decoder
    import priority_pkg::*;
#(
    parameter int INPUTS      = 3,
    parameter int CODE_WIDTH  = $clog2(INPUTS),
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    priority_decoder_if.slave bus,
    output logic [INPUTS-1:0] onehot,
    output logic              busy,
    output logic              err,
    output logic [INPUTS-1:0] acc,
    input  logic              acc_clr
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CWR  = $clog2(MAXC + 1);
    localparam int CW   = (CWR < 1) ? 1 : CWR;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic          HAS_GAP = (GAP_CYCLES > 0);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              accept;
    logic              code_ok;
    logic              load_code;
    logic              hold_end;
    logic [INPUTS-1:0] dec_bit;
    logic              cnt_load;
    logic [CW-1:0]     cnt_val;
    logic              cnt_dec;
    logic              cnt_zero;

    assign bus.code_ready = (state == IDLE);
    assign busy           = (state != IDLE);

    assign accept    = bus.code_valid & bus.code_ready;
    assign code_ok   = (32'(bus.code) < INPUTS);
    assign load_code = accept & code_ok;
    assign hold_end  = (state == HOLD) & cnt_zero;
    assign dec_bit   = INPUTS'(code_to_bit(32'(bus.code), INPUTS));

    assign cnt_load = load_code | (hold_end & HAS_GAP);
    assign cnt_val  = (state == IDLE) ? HOLD_LD : GAP_LD;
    assign cnt_dec  = (state != IDLE);

    priority_decoder_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (load_code) state_nxt = HOLD;
            HOLD:    if (cnt_zero) state_nxt = HAS_GAP ? GAP : IDLE;
            GAP:     if (cnt_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            onehot <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= accept & ~code_ok;
            if (load_code)
                onehot <= dec_bit;
            else if (hold_end)
                onehot <= '0;
        end
    end

`ifdef PRIORITY_DECODER_ACC_EN
    // Clear is applied before the new bit is ORed in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (acc_clr || load_code)
            acc <= (acc_clr ? '0 : acc) | (load_code ? dec_bit : '0);
    end
`else
    logic acc_clr_unused;
    assign acc_clr_unused = acc_clr;
    assign acc            = '0;
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Self-checking bench for priority_decoder: timeline model plus directed
// vectors; second instance (INPUTS=5, GAP_CYCLES=0) checks the round trip.
module tb_priority_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       acc_clr = 1'b0;
    logic [2:0] onehot;
    logic       busy;
    logic       err;
    logic [2:0] acc;

    logic [4:0] onehot5;
    logic       busy5;
    logic       err5;
    logic [4:0] acc5;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_decoder_if #(.CODE_WIDTH(2)) bus3 ();
    priority_decoder_if #(.CODE_WIDTH(3)) bus5 ();

    priority_decoder #(
        .INPUTS      (3),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus3),
        .onehot  (onehot),
        .busy    (busy),
        .err     (err),
        .acc     (acc),
        .acc_clr (acc_clr)
    );

    priority_decoder #(
        .INPUTS      (5),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (0)
    ) dut5 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus5),
        .onehot  (onehot5),
        .busy    (busy5),
        .err     (err5),
        .acc     (acc5),
        .acc_clr (1'b0)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted good code owns the output for 4 strobe
    // cycles plus 1 gap cycle; the block is ready whenever nothing is pending.
    int         busy_left;
    int         hold_left;
    logic [2:0] cur_m;
    logic       err_m;
    logic [2:0] acc_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left <= 0;
            hold_left <= 0;
            cur_m     <= 3'b000;
            err_m     <= 1'b0;
            acc_m     <= 3'b000;
        end else begin
            err_m <= 1'b0;
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (hold_left > 0)
                    hold_left <= hold_left - 1;
`ifdef PRIORITY_DECODER_ACC_EN
                if (acc_clr)
                    acc_m <= 3'b000;
`endif
            end else if (bus3.code_valid && bus3.code < 3) begin
                cur_m     <= 3'b100 >> bus3.code;
                hold_left <= 4;
                busy_left <= 5;
`ifdef PRIORITY_DECODER_ACC_EN
                acc_m <= (acc_clr ? 3'b000 : acc_m) | (3'b100 >> bus3.code);
`endif
            end else begin
                if (bus3.code_valid)
                    err_m <= 1'b1;
`ifdef PRIORITY_DECODER_ACC_EN
                if (acc_clr)
                    acc_m <= 3'b000;
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("onehot", int'(onehot), int'(hold_left > 0 ? cur_m : 3'b000));
        check("busy", int'(busy), int'(busy_left > 0));
        check("ready", int'(bus3.code_ready), int'(busy_left == 0));
        check("err", int'(err), int'(err_m));
        check("acc", int'(acc), int'(acc_m));
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus3.code_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", int'(bus3.code_ready), 1);
    endtask

    task automatic send(input logic [1:0] c);
        bus3.code_valid = 1'b1;
        bus3.code       = c;
        @(posedge clk);
        #1;
        bus3.code_valid = 1'b0;
    endtask

    function automatic int encode5(input logic [4:0] v);
        int e = -1;
        for (int b = 0; b < 5; b++)
            if (v[b])
                e = 4 - b;
        return e;
    endfunction

    initial begin
        bus3.code_valid = 1'b0;
        bus3.code       = 2'd0;
        bus5.code_valid = 1'b0;
        bus5.code       = 3'd0;

        #3;
        check("rst_onehot", int'(onehot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", int'(bus3.code_ready), 1);

        // code 0 -> 100 for 4 cycles, gap, ready
        wait_ready();
        send(2'd0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("c0_onehot", int'(onehot), (j < 4) ? 4 : 0);
            check("c0_busy", int'(busy), int'(j < 5));
            check("c0_ready", int'(bus3.code_ready), int'(j >= 5));
        end

        // code 2 -> 001, busy 5 cycles
        wait_ready();
        send(2'd2);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("c2_onehot", int'(onehot), (j < 4) ? 1 : 0);
            check("c2_busy", int'(busy), int'(j < 5));
        end

        // invalid code 3 then code 1 one cycle later
        wait_ready();
        send(2'd3);
        @(negedge clk);
        check("c3_err", int'(err), 1);
        check("c3_onehot", int'(onehot), 0);
        check("c3_ready", int'(bus3.code_ready), 1);
        send(2'd1);
        @(negedge clk);
        check("c1_onehot", int'(onehot), 2);
        check("c1_err", int'(err), 0);

        // back-to-back with valid held high: 1 then 0
        wait_ready();
        bus3.code_valid = 1'b1;
        bus3.code       = 2'd1;
        @(posedge clk);
        #1 bus3.code = 2'd0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("b2b_onehot", int'(onehot), (j < 4) ? 2 : (j < 6) ? 0 : 4);
            if (j == 5)
                check("b2b_ready", int'(bus3.code_ready), 1);
        end
        bus3.code_valid = 1'b0;

        // async reset in the 2nd HOLD cycle
        wait_ready();
        send(2'd2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_onehot", int'(onehot), 0);
        check("rstmid_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_ready", int'(bus3.code_ready), 1);
        send(2'd1);
        @(negedge clk);
        check("rstmid_onehot2", int'(onehot), 2);

`ifdef PRIORITY_DECODER_ACC_EN
        wait_ready();
        acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        check("acc_clr", int'(acc), 0);
        send(2'd0);
        wait_ready();
        send(2'd2);
        @(negedge clk);
        check("acc_101", int'(acc), 5);
        wait_ready();
        acc_clr = 1'b1;
        send(2'd1);
        acc_clr = 1'b0;
        @(negedge clk);
        check("acc_clr_load", int'(acc), 2);
`else
        check("acc_off", int'(acc), 0);
`endif

        // round trip on the 5-wide, no-gap instance
        for (int c = 0; c < 5; c++) begin
            int n = 0;
            while (!bus5.code_ready && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("rt_ready", int'(bus5.code_ready), 1);
            bus5.code_valid = 1'b1;
            bus5.code       = 3'(c);
            @(posedge clk);
            #1 bus5.code_valid = 1'b0;
            @(negedge clk);
            check("rt_code", encode5(onehot5), c);
            check("rt_pop", $countones(onehot5), 1);
        end

        repeat (8) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
